tlb_op_ctrl: RTL and testbench

Multi-cycle sequencer for the TLB maintenance instructions TLBR, TLBWI and TLBP. It sits between the execute stage, the TLB entry array and the coprocessor-0 register file. It owns the CP0 single write port for the duration of an operation, issues array reads and writes, and scans the array for TLBP. The pipeline stalls on `op_ready` low.

---
 rtl/tlb_op_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// Multi-cycle sequencer for TLBR / TLBWI / TLBP: drives the TLB array and owns the CP0 write port.
// Build option: define TLB_PROBE_EARLY_EXIT_EN to end a TLBP scan on its first hit.
module tlb_op_ctrl #(
    parameter int TLB_ENTRIES = 16,
    localparam int IW = $clog2(TLB_ENTRIES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          op_valid,
    input  logic [1:0]    op_type,
    output logic          op_ready,
    output logic          op_done,
    input  logic [31:0]   cp0_entryhi,
    input  logic [31:0]   cp0_entrylo0,
    input  logic [31:0]   cp0_entrylo1,
    input  logic [31:0]   cp0_pagemask,
    input  logic [31:0]   cp0_index,
    output logic [IW-1:0] tlb_idx,
    output logic          tlb_ren,
    input  logic [18:0]   tlb_rd_vpn2,
    input  logic [7:0]    tlb_rd_asid,
    input  logic          tlb_rd_g,
    input  logic [11:0]   tlb_rd_mask,
    input  logic [24:0]   tlb_rd_lo0,
    input  logic [24:0]   tlb_rd_lo1,
    output logic          tlb_wen,
    output logic [18:0]   tlb_wr_vpn2,
    output logic [7:0]    tlb_wr_asid,
    output logic          tlb_wr_g,
    output logic [11:0]   tlb_wr_mask,
    output logic [24:0]   tlb_wr_lo0,
    output logic [24:0]   tlb_wr_lo1,
    output logic          cp0_wen,
    output logic [7:0]    cp0_waddr,
    output logic [31:0]   cp0_wdata,
    output logic          probe_miss,
    output logic [3:0]    dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_WRITE, S_READ, S_CAPT, S_WB_HI,
        S_WB_LO0, S_WB_LO1, S_WB_PM, S_SCAN, S_WB_IDX
    } state_t;

    localparam logic [1:0] OP_TLBR  = 2'b00;
    localparam logic [1:0] OP_TLBWI = 2'b01;
    localparam logic [1:0] OP_TLBP  = 2'b10;
    localparam logic [IW:0] TERM_CNT = (IW+1)'(TLB_ENTRIES);

    state_t state, state_nxt;

    logic [1:0]    type_q;
    logic [18:0]   hi_vpn2_q;
    logic [7:0]    hi_asid_q;
    logic [25:0]   lo0_q, lo1_q;
    logic [11:0]   mask_q;
    logic [IW-1:0] idx_q;

    logic [18:0]   rd_vpn2_q;
    logic [7:0]    rd_asid_q;
    logic          rd_g_q;
    logic [11:0]   rd_mask_q;
    logic [24:0]   rd_lo0_q, rd_lo1_q;

    logic [IW:0]   cnt;
    logic [IW:0]   cnt_m1;
    logic          hit_found;
    logic [IW-1:0] hit_idx;

    logic          accept;
    logic [18:0]   mask_ext;
    logic          scan_hit;
    logic          new_hit;

    logic          unused_bits;
    assign unused_bits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26],
                           cp0_pagemask[31:25], cp0_pagemask[12:0], cp0_index[31:IW]};

    assign accept   = (state == S_IDLE) && op_valid;
    assign op_ready = (state == S_IDLE);
    assign dbg_state = state;

    // Read data on the bus belongs to the index issued in the previous SCAN cycle.
    assign mask_ext = {7'b0, tlb_rd_mask};
    assign scan_hit = ((tlb_rd_vpn2 & ~mask_ext) == (hi_vpn2_q & ~mask_ext)) &&
                      (tlb_rd_g || (tlb_rd_asid == hi_asid_q));
    assign new_hit  = (state == S_SCAN) && (cnt != '0) && scan_hit && !hit_found;
    assign cnt_m1   = cnt - 1'b1;

    assign tlb_wr_vpn2 = hi_vpn2_q;
    assign tlb_wr_asid = hi_asid_q;
    assign tlb_wr_mask = mask_q;
    assign tlb_wr_lo0  = lo0_q[25:1];
    assign tlb_wr_lo1  = lo1_q[25:1];
    assign tlb_wr_g    = lo0_q[0] & lo1_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            type_q     <= '0;
            hi_vpn2_q  <= '0;
            hi_asid_q  <= '0;
            lo0_q      <= '0;
            lo1_q      <= '0;
            mask_q     <= '0;
            idx_q      <= '0;
            rd_vpn2_q  <= '0;
            rd_asid_q  <= '0;
            rd_g_q     <= 1'b0;
            rd_mask_q  <= '0;
            rd_lo0_q   <= '0;
            rd_lo1_q   <= '0;
            cnt        <= '0;
            hit_found  <= 1'b0;
            hit_idx    <= '0;
            probe_miss <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                type_q    <= op_type;
                hi_vpn2_q <= cp0_entryhi[31:13];
                hi_asid_q <= cp0_entryhi[7:0];
                lo0_q     <= cp0_entrylo0[25:0];
                lo1_q     <= cp0_entrylo1[25:0];
                mask_q    <= cp0_pagemask[24:13];
                idx_q     <= cp0_index[IW-1:0];
                cnt       <= '0;
                hit_found <= 1'b0;
                hit_idx   <= '0;
            end
            if (state == S_CAPT) begin
                rd_vpn2_q <= tlb_rd_vpn2;
                rd_asid_q <= tlb_rd_asid;
                rd_g_q    <= tlb_rd_g;
                rd_mask_q <= tlb_rd_mask;
                rd_lo0_q  <= tlb_rd_lo0;
                rd_lo1_q  <= tlb_rd_lo1;
            end
            if (state == S_SCAN) begin
                cnt <= cnt + 1'b1;
                if (new_hit) begin
                    hit_found <= 1'b1;
                    hit_idx   <= cnt_m1[IW-1:0];
                end
            end
            if ((state == S_WB_IDX) && (type_q == OP_TLBP)) begin
                probe_miss <= !hit_found;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        op_done   = 1'b0;
        tlb_ren   = 1'b0;
        tlb_wen   = 1'b0;
        tlb_idx   = '0;
        cp0_wen   = 1'b0;
        cp0_waddr = '0;
        cp0_wdata = '0;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    case (op_type)
                        OP_TLBR:  state_nxt = S_READ;
                        OP_TLBWI: state_nxt = S_WRITE;
                        OP_TLBP:  state_nxt = S_SCAN;
                        default:  state_nxt = S_WB_IDX;
                    endcase
                end
            end
            S_WRITE: begin
                tlb_wen   = 1'b1;
                tlb_idx   = idx_q;
                op_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_READ: begin
                tlb_ren   = 1'b1;
                tlb_idx   = idx_q;
                state_nxt = S_CAPT;
            end
            S_CAPT: state_nxt = S_WB_HI;
            S_WB_HI: begin
                cp0_wen   = 1'b1;
                cp0_waddr = {5'd10, 3'd0};
                cp0_wdata = {rd_vpn2_q, 5'b0, rd_asid_q};
                state_nxt = S_WB_LO0;
            end
            S_WB_LO0: begin
                cp0_wen   = 1'b1;
                cp0_waddr = {5'd2, 3'd0};
                cp0_wdata = {6'b0, rd_lo0_q, rd_g_q};
                state_nxt = S_WB_LO1;
            end
            S_WB_LO1: begin
                cp0_wen   = 1'b1;
                cp0_waddr = {5'd3, 3'd0};
                cp0_wdata = {6'b0, rd_lo1_q, rd_g_q};
                state_nxt = S_WB_PM;
            end
            S_WB_PM: begin
                cp0_wen   = 1'b1;
                cp0_waddr = {5'd5, 3'd0};
                cp0_wdata = {7'b0, rd_mask_q, 13'b0};
                op_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_SCAN: begin
                tlb_ren = 1'b1;
                tlb_idx = cnt[IW-1:0];
                if (cnt == TERM_CNT) begin
                    state_nxt = S_WB_IDX;
                end
`ifdef TLB_PROBE_EARLY_EXIT_EN
                else if (new_hit) begin
                    state_nxt = S_WB_IDX;
                end
`endif
            end
            S_WB_IDX: begin
                // A reserved op lands here too, but must not touch CP0.
                if (type_q == OP_TLBP) begin
                    cp0_wen   = 1'b1;
                    cp0_waddr = {5'd0, 3'd0};
                    cp0_wdata = {!hit_found, {(31-IW){1'b0}}, hit_idx};
                end
                op_done   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed scoreboard bench for tlb_op_ctrl: driver pushes expected CP0/TLB writes and
// completion cycles; a negedge monitor pops and compares whenever the DUT presents them.
module tb_tlb_op_ctrl;
    localparam int TLB_ENTRIES = 16;
    localparam int IW = 4;
`ifdef TLB_PROBE_EARLY_EXIT_EN
    localparam int HIT9_LAT = 12;
`else
    localparam int HIT9_LAT = 18;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_valid;
    logic [1:0]    op_type;
    logic          op_ready, op_done;
    logic [31:0]   cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_pagemask, cp0_index;
    logic [IW-1:0] tlb_idx;
    logic          tlb_ren;
    logic [18:0]   tlb_rd_vpn2 = '0;
    logic [7:0]    tlb_rd_asid = '0;
    logic          tlb_rd_g = 1'b0;
    logic [11:0]   tlb_rd_mask = '0;
    logic [24:0]   tlb_rd_lo0 = '0, tlb_rd_lo1 = '0;
    logic          tlb_wen;
    logic [18:0]   tlb_wr_vpn2;
    logic [7:0]    tlb_wr_asid;
    logic          tlb_wr_g;
    logic [11:0]   tlb_wr_mask;
    logic [24:0]   tlb_wr_lo0, tlb_wr_lo1;
    logic          cp0_wen;
    logic [7:0]    cp0_waddr;
    logic [31:0]   cp0_wdata;
    logic          probe_miss;
    logic [3:0]    dbg_state;

    tlb_op_ctrl #(.TLB_ENTRIES(TLB_ENTRIES)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_type(op_type),
        .op_ready(op_ready), .op_done(op_done),
        .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
        .cp0_pagemask(cp0_pagemask), .cp0_index(cp0_index),
        .tlb_idx(tlb_idx), .tlb_ren(tlb_ren),
        .tlb_rd_vpn2(tlb_rd_vpn2), .tlb_rd_asid(tlb_rd_asid), .tlb_rd_g(tlb_rd_g),
        .tlb_rd_mask(tlb_rd_mask), .tlb_rd_lo0(tlb_rd_lo0), .tlb_rd_lo1(tlb_rd_lo1),
        .tlb_wen(tlb_wen), .tlb_wr_vpn2(tlb_wr_vpn2), .tlb_wr_asid(tlb_wr_asid),
        .tlb_wr_g(tlb_wr_g), .tlb_wr_mask(tlb_wr_mask), .tlb_wr_lo0(tlb_wr_lo0),
        .tlb_wr_lo1(tlb_wr_lo1),
        .cp0_wen(cp0_wen), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .probe_miss(probe_miss), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- TLB array model (1-cycle read latency) ----------------
    logic [89:0] mem [TLB_ENTRIES];
    logic        mdl_init = 1'b0;

    function automatic logic [89:0] init_entry(input int i);
        case (i)
            3:  return {19'h7FFFF, 8'h11, 1'b1, 12'hFFF, 25'h1ABCDEF, 25'h0123456};
            4:  return {19'h12345, 8'h23, 1'b0, 12'h000, 25'h0, 25'h0};
            9:  return {19'h12345, 8'h22, 1'b0, 12'h000, 25'h1, 25'h0};
            12: return {19'h12000, 8'h99, 1'b1, 12'hFFF, 25'h0, 25'h0};
            default: return {19'(32'h40000 + i), 8'h55, 1'b0, 12'h000, 25'h0, 25'h0};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!mdl_init) begin
            for (int i = 0; i < TLB_ENTRIES; i++) mem[i] <= init_entry(i);
            mdl_init <= 1'b1;
        end else begin
            if (tlb_ren) {tlb_rd_vpn2, tlb_rd_asid, tlb_rd_g, tlb_rd_mask, tlb_rd_lo0, tlb_rd_lo1} <= mem[tlb_idx];
            if (tlb_wen) mem[tlb_idx] <= {tlb_wr_vpn2, tlb_wr_asid, tlb_wr_g, tlb_wr_mask, tlb_wr_lo0, tlb_wr_lo1};
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [71:0]  cp0_exp_q[$];   // {cycle, addr, data}
    logic [125:0] tlbw_exp_q[$];  // {cycle, idx, vpn2, asid, g, mask, lo0, lo1}
    logic [33:0]  done_exp_q[$];  // {cycle, is_probe, miss}

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_cp0(input int c, input logic [7:0] a, input logic [31:0] d);
        cp0_exp_q.push_back({32'(c), a, d});
    endtask

    task automatic exp_tlbw(input int c, input logic [93:0] f);
        tlbw_exp_q.push_back({32'(c), f});
    endtask

    task automatic exp_done(input int c, input logic is_probe, input logic miss);
        done_exp_q.push_back({32'(c), is_probe, miss});
    endtask

    // ---------------- monitor ----------------
    logic pm_pending = 1'b0;
    logic pm_exp = 1'b0;
    logic [71:0]  cp0_e;
    logic [125:0] tlbw_e;
    logic [33:0]  done_e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (pm_pending) begin
                    chk("probe_miss", 128'(probe_miss), 128'(pm_exp));
                    pm_pending = 1'b0;
                end
                if (op_ready) chk("idle_strobes", 128'({cp0_wen, tlb_wen, op_done}), 128'(0));
                if (cp0_wen) begin
                    if (cp0_exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL cp0_unexpected: got addr %0h data %0h expected no write (cycle %0d)",
                                 cp0_waddr, cp0_wdata, cyc);
                    end else begin
                        cp0_e = cp0_exp_q.pop_front();
                        chk("cp0_write", 128'({32'(cyc), cp0_waddr, cp0_wdata}), 128'(cp0_e));
                    end
                end
                if (tlb_wen) begin
                    if (tlbw_exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tlbw_unexpected: got idx %0h expected no write (cycle %0d)", tlb_idx, cyc);
                    end else begin
                        tlbw_e = tlbw_exp_q.pop_front();
                        chk("tlb_write", 128'({32'(cyc), tlb_idx, tlb_wr_vpn2, tlb_wr_asid, tlb_wr_g,
                                               tlb_wr_mask, tlb_wr_lo0, tlb_wr_lo1}), 128'(tlbw_e));
                    end
                end
                if (op_done) begin
                    if (done_exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected: got op_done expected none (cycle %0d)", cyc);
                    end else begin
                        done_e = done_exp_q.pop_front();
                        chk("op_done_cycle", 128'(cyc), 128'(done_e[33:2]));
                        if (done_e[1]) begin
                            pm_pending = 1'b1;
                            pm_exp     = done_e[0];
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [1:0] t, input logic [31:0] hi, input logic [31:0] lo0,
                         input logic [31:0] lo1, input logic [31:0] pm, input logic [31:0] idx,
                         input logic keep, output int t_acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got op_ready 0 expected 1 (cycle %0d)", cyc);
        end
        op_valid = 1'b1; op_type = t;
        cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
        cp0_pagemask = pm; cp0_index = idx;
        t_acc = cyc;
        @(posedge clk);
        #1;
        // Scramble CP0 and keep a live-looking request while busy.
        op_valid = keep; op_type = 2'b10;
        cp0_entryhi = ~hi; cp0_entrylo0 = ~lo0; cp0_entrylo1 = ~lo1;
        cp0_pagemask = ~pm; cp0_index = ~idx;
    endtask

    task automatic push_tlbr3(input int t);
        exp_cp0(t + 3, 8'h50, 32'hFFFFE011);
        exp_cp0(t + 4, 8'h10, 32'h03579BDF);
    endtask

    int t;

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_type = 2'b00;
        cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0; cp0_pagemask = '0; cp0_index = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_op_ready", 128'(op_ready), 128'(1));
        chk("rst_op_done", 128'(op_done), 128'(0));
        chk("rst_strobes", 128'({tlb_ren, tlb_wen, cp0_wen}), 128'(0));
        chk("rst_probe_miss", 128'(probe_miss), 128'(0));
        chk("rst_tlb_idx", 128'(tlb_idx), 128'(0));
        chk("rst_cp0_bus", 128'({cp0_waddr, cp0_wdata}), 128'(0));

        // TLBWI index 5
        issue(2'b01, 32'h1234A03C, 32'h00000041, 32'h00000082, 32'h0001E000, 32'h5, 1'b0, t);
        exp_tlbw(t + 1, {4'd5, 19'h091A5, 8'h3C, 1'b0, 12'h00F, 25'h20, 25'h41});
        exp_done(t + 1, 1'b0, 1'b0);

        // TLBR entry 3
        issue(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 1'b0, t);
        push_tlbr3(t);
        exp_cp0(t + 5, 8'h18, 32'h002468AD);
        exp_cp0(t + 6, 8'h28, 32'h01FFE000);
        exp_done(t + 6, 1'b0, 1'b0);

        // TLBP miss: entry 7 has same vpn2 but other ASID and g=0
        issue(2'b10, 32'h8000E056, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, t);
        exp_cp0(t + 18, 8'h00, 32'h80000000);
        exp_done(t + 18, 1'b1, 1'b1);

        // TLBP hitting entries 9 and 12 (12 via mask, global)
        issue(2'b10, 32'h2468A022, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, t);
        exp_cp0(t + HIT9_LAT, 8'h00, 32'h00000009);
        exp_done(t + HIT9_LAT, 1'b1, 1'b0);

        // Reserved op: NOP with completion pulse
        issue(2'b11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, t);
        exp_done(t + 1, 1'b0, 1'b0);

        // Back-to-back with op_valid held high and CP0 scrambled mid-op
        issue(2'b01, 32'hABCDE0FF, 32'h03FFFFFF, 32'h00000003, 32'h00006000, 32'h2, 1'b1, t);
        exp_tlbw(t + 1, {4'd2, 19'h55E6F, 8'hFF, 1'b1, 12'h003, 25'h1FFFFFF, 25'h1});
        exp_done(t + 1, 1'b0, 1'b0);
        issue(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h2, 1'b1, t);
        exp_cp0(t + 3, 8'h50, 32'hABCDE0FF);
        exp_cp0(t + 4, 8'h10, 32'h03FFFFFF);
        exp_cp0(t + 5, 8'h18, 32'h00000003);
        exp_cp0(t + 6, 8'h28, 32'h00006000);
        exp_done(t + 6, 1'b0, 1'b0);
        issue(2'b11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, t);
        exp_done(t + 1, 1'b0, 1'b0);

        // Reset during WB_LO0 of a TLBR
        issue(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 1'b0, t);
        push_tlbr3(t);
        while (cyc < t + 4) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_cp0_wen", 128'(cp0_wen), 128'(0));
        chk("midrst_cp0_bus", 128'({cp0_waddr, cp0_wdata}), 128'(0));
        chk("midrst_done_idx", 128'({op_done, tlb_idx}), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_op_ready", 128'(op_ready), 128'(1));
        chk("postrst_probe_miss", 128'(probe_miss), 128'(0));

        issue(2'b01, 32'h00002001, 32'h00000001, 32'h00000003, 32'h0, 32'h7, 1'b0, t);
        exp_tlbw(t + 1, {4'd7, 19'h00001, 8'h01, 1'b1, 12'h000, 25'h0, 25'h1});
        exp_done(t + 1, 1'b0, 1'b0);

        // Drain with a bounded wait
        for (int i = 0; i < 200; i++) begin
            if (cp0_exp_q.size() == 0 && tlbw_exp_q.size() == 0 && done_exp_q.size() == 0 && !pm_pending)
                break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("left_cp0_writes", 128'(cp0_exp_q.size()), 128'(0));
        chk("left_tlb_writes", 128'(tlbw_exp_q.size()), 128'(0));
        chk("left_done", 128'(done_exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
